pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the RISC-V pipeline's fetch stage. It holds the current fetch address, advances by a fixed increment when the fetch stage accepts it, and redirects on branch/jump and trap requests. A redirect that arrives during a stall is buffered until the stall ends. A misaligned redirect target is caught and parks the unit in an error state until a trap or reset. Outputs feed the instruction-memory address port and the IF/ID pipeline register.

## Interface
- XLEN, 32: address width in bits
- RESET_VECTOR, 32'h0000_0000: pc_out value during and after reset
- TRAP_VECTOR, 32'h0000_0100: target loaded on trap_valid
- INC, 4: increment per accepted fetch
- ALIGN_BITS, 2: number of LSBs of a redirect target that must be zero

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard stall from decode/hazard unit; freezes PC
- fetch_ready  in  1  fetch stage accepts pc_out this cycle
- redirect_valid  in  1  branch/jump taken, resolved in EX
- redirect_pc  in  XLEN  branch/jump target
- trap_valid  in  1  trap/exception entry request
- pc_out  out  XLEN  current fetch address (registered)
- pc_plus_inc  out  XLEN  pc_out + INC, combinational, wraps mod 2^XLEN
- pc_valid  out  1  pc_out is a valid fetch address (registered)
- misalign_err  out  1  sticky error flag (registered)
- err_addr  out  XLEN  offending redirect target (registered)

## Operation
- States: BOOT, RUN, PEND, ERR. A pending register (pend_pc) holds the buffered redirect target.
- Reset (async, while rst_n=0): state=BOOT, pc_out=RESET_VECTOR, pc_valid=0, misalign_err=0, err_addr=0, pend_pc=0.
- BOOT: on the first clock edge after rst_n rises, pc_valid<=1 and state<=RUN. pc_out stays RESET_VECTOR.
- Per-edge priority, high to low: trap_valid > redirect_valid > increment.
- trap_valid in any state other than BOOT:
  - pc_out<=TRAP_VECTOR, pc_valid<=1, state<=RUN.
  - misalign_err<=0; pend_pc is discarded.
  - Applies regardless of stall, fetch_ready or redirect_valid.
- redirect_valid with a misaligned target (redirect_pc[ALIGN_BITS-1:0]!=0), in RUN or PEND:
  - state<=ERR, pc_valid<=0, misalign_err<=1, err_addr<=redirect_pc.
  - pc_out holds.
- redirect_valid with an aligned target in RUN or PEND:
  - If stall=0: pc_out<=redirect_pc, pc_valid<=1, state<=RUN.
  - If stall=1: pend_pc<=redirect_pc, pc_valid<=0, state<=PEND. pc_out holds.
  - Last redirect wins while in PEND.
- Increment in RUN: if stall=0, fetch_ready=1 and no trap/redirect, then pc_out<=pc_out+INC, wrapping mod 2^XLEN (no carry out). Otherwise pc_out holds.
- PEND, no trap/redirect:
  - stall=1: hold, pc_valid=0.
  - stall=0: pc_out<=pend_pc, pc_valid<=1, state<=RUN.
- ERR:
  - Ignores stall, fetch_ready and redirect_valid.
  - pc_valid=0 and misalign_err=1 until trap_valid or reset.
  - err_addr holds its value in ERR.
- BOOT ignores trap_valid and redirect_valid; they are not buffered.

## Timing
- Every output except pc_plus_inc is registered. Inputs take effect on pc_out one edge later.
- Redirect with stall=0: the target appears on pc_out the cycle after redirect_valid. No bubble beyond that.
- Redirect with stall=1: the target appears on pc_out the cycle after the first cycle with stall=0. pc_valid is low for the whole PEND interval.
- Simultaneous trap_valid and redirect_valid: the trap wins and the redirect is dropped.
- Simultaneous stall=0 and a new aligned redirect in PEND: the new redirect_pc is loaded directly and the old pend_pc is discarded.
- Reset asserted mid-PEND or mid-ERR: immediate return to reset values with no clock required. BOOT lasts exactly one cycle after release.
- Wrap-around: pc_out=32'hFFFF_FFFC with INC=4 advances to 32'h0000_0000 with pc_valid=1.

## Test plan
- Reset release with stall=0 and fetch_ready=1 -> pc_out=0x0 for two edges (BOOT, then first fetch), then 0x4, 0x8, 0xC. pc_valid rises one edge after reset release.
- Aligned redirect to 0x200 with stall=0 at pc=0x10 -> next pc_out=0x200, then 0x204. pc_valid stays 1.
- Redirect to 0x300 with stall=1 for 3 cycles, plus a second redirect to 0x400 during the stall -> pc_valid=0 and pc_out frozen during the stall. pc_out=0x400 one edge after stall drops.
- Redirect to 0x202 -> misalign_err=1, err_addr=0x202, pc_valid=0, and later redirects are ignored. trap_valid then gives pc_out=0x100, misalign_err=0, pc_valid=1.
- trap_valid and redirect_valid (0x500) on the same edge while stall=1 -> pc_out=0x100 next cycle, state RUN, no pending redirect applied afterwards.
- pc=0xFFFF_FFFC with fetch_ready=1 -> pc_out=0x0000_0000 and pc_plus_inc=0x4. rst_n pulsed low mid-PEND -> pc_out=0x0 and pc_valid=0 asynchronously.

Source files
------------

// File: rtl/pc_gen_if.sv
// pc_gen_if: bundles the fetch-control inputs and program-counter outputs of pc_gen.
//   master modport: the pipeline side. It drives stall, fetch_ready,
//                   redirect_valid, redirect_pc and trap_valid, and it
//                   observes the PC outputs.
//   slave modport:  the pc_gen side. It receives the control inputs and drives
//                   pc_out, pc_plus_inc, pc_valid, misalign_err and err_addr.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            fetch_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_valid;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_plus_inc;
    logic            pc_valid;
    logic            misalign_err;
    logic [XLEN-1:0] err_addr;

    modport master (
        output stall, fetch_ready, redirect_valid, redirect_pc, trap_valid,
        input  pc_out, pc_plus_inc, pc_valid, misalign_err, err_addr
    );

    modport slave (
        input  stall, fetch_ready, redirect_valid, redirect_pc, trap_valid,
        output pc_out, pc_plus_inc, pc_valid, misalign_err, err_addr
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_gen_if.slave
//           inputs  : stall, fetch_ready, redirect_valid, redirect_pc, trap_valid
//           outputs : pc_out (registered)
//                     pc_plus_inc (combinational: pc_out + INC)
//                     pc_valid (registered)
//                     misalign_err (registered)
//                     err_addr (registered)
// Behaviour:
//   - The PC advances by INC on each accepted fetch.
//   - A branch/jump redirect loads its target on the next edge. If the redirect
//     arrives during a stall, the target is buffered until the stall ends.
//   - A trap loads TRAP_VECTOR and clears the error state.
//   - A misaligned redirect target parks the unit in ERR until a trap or reset.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_gen_if.slave      bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        ERR  = 2'd3
    } state_t;

    // A mask built from a shift stays legal when ALIGN_BITS is 0; a part-select
    // [ALIGN_BITS-1:0] would not be.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pend_pc_reg;
    logic [XLEN-1:0] err_addr_reg;
    logic            pc_valid_reg;
    logic            misalign_err_reg;
    logic            redirect_misaligned;

    assign redirect_misaligned = |(bus.redirect_pc & ALIGN_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BOOT;
            pc_reg           <= RESET_VECTOR;
            pend_pc_reg      <= '0;
            err_addr_reg     <= '0;
            pc_valid_reg     <= 1'b0;
            misalign_err_reg <= 1'b0;
        end else if (state_reg == BOOT) begin
            // Single settling cycle. Traps and redirects seen here are dropped.
            pc_valid_reg <= 1'b1;
            state_reg    <= RUN;
        end else if (bus.trap_valid) begin
            // A trap overrides everything, including ERR and a buffered redirect.
            pc_reg           <= TRAP_VECTOR;
            pc_valid_reg     <= 1'b1;
            misalign_err_reg <= 1'b0;
            pend_pc_reg      <= '0;
            state_reg        <= RUN;
        end else if (state_reg == ERR) begin
            pc_valid_reg     <= 1'b0;
            misalign_err_reg <= 1'b1;
        end else if (bus.redirect_valid) begin
            if (redirect_misaligned) begin
                pc_valid_reg     <= 1'b0;
                misalign_err_reg <= 1'b1;
                err_addr_reg     <= bus.redirect_pc;
                state_reg        <= ERR;
            end else if (!bus.stall) begin
                // Any older buffered target is superseded here.
                pc_reg       <= bus.redirect_pc;
                pc_valid_reg <= 1'b1;
                state_reg    <= RUN;
            end else begin
                // Last redirect seen while stalled wins.
                pend_pc_reg  <= bus.redirect_pc;
                pc_valid_reg <= 1'b0;
                state_reg    <= PEND;
            end
        end else if (state_reg == PEND) begin
            if (!bus.stall) begin
                pc_reg       <= pend_pc_reg;
                pc_valid_reg <= 1'b1;
                state_reg    <= RUN;
            end else begin
                pc_valid_reg <= 1'b0;
            end
        end else if (!bus.stall && bus.fetch_ready) begin
            // The addition wraps modulo 2^XLEN; any carry out is discarded.
            pc_reg <= pc_reg + XLEN'(INC);
        end
    end

    assign bus.pc_out       = pc_reg;
    assign bus.pc_plus_inc  = pc_reg + XLEN'(INC);
    assign bus.pc_valid     = pc_valid_reg;
    assign bus.misalign_err = misalign_err_reg;
    assign bus.err_addr     = err_addr_reg;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen (XLEN=32, INC=4, ALIGN_BITS=2).
// The bench has four parts:
//   - a directed vector table,
//   - hand-written multi-cycle corner sequences,
//   - a randomized run checked against a behavioural model,
//   - one summary line at the end.
module tb_pc_gen;
    localparam logic [31:0] TRAP_PC = 32'h0000_0100;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
        .INC(4), .ALIGN_BITS(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          st;
        bit          fr;
        bit          rv;
        logic [31:0] rpc;
        bit          tv;
        logic [31:0] pc;
        bit          v;
        bit          e;
        logic [31:0] ea;
    } vec_t;

    vec_t vecs[22];

    // Behavioural model: the fetch address plus a few facts about the unit.
    // These facts are: has it booted, is a target waiting, is it in error.
    logic [31:0] m_pc, m_pend, m_eaddr;
    bit          m_booted, m_pending, m_err, m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] pc, input bit v,
                                 input bit e, input logic [31:0] ea);
        logic [31:0] nxt;
        nxt = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
        chk($sformatf("%s.pc_out", tag), bus.pc_out, pc);
        chk($sformatf("%s.pc_plus_inc", tag), bus.pc_plus_inc, nxt);
        chk($sformatf("%s.pc_valid", tag), 32'(bus.pc_valid), 32'(v));
        chk($sformatf("%s.misalign_err", tag), 32'(bus.misalign_err), 32'(e));
        chk($sformatf("%s.err_addr", tag), bus.err_addr, ea);
        $display("%s: pc=%h valid=%0b err=%0b err_addr=%h", tag, bus.pc_out,
                 bus.pc_valid, bus.misalign_err, bus.err_addr);
    endtask

    task automatic drive(input bit st, input bit fr, input bit rv,
                         input logic [31:0] rpc, input bit tv);
        bus.stall          = st;
        bus.fetch_ready    = fr;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.trap_valid     = tv;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_pend = 32'h0; m_eaddr = 32'h0;
        m_booted = 0; m_pending = 0; m_err = 0; m_valid = 0;
    endtask

    // One rising edge of the model, following the stated priority rules.
    task automatic model_edge(input bit st, input bit fr, input bit rv,
                              input logic [31:0] rpc, input bit tv);
        if (!m_booted) begin
            m_booted = 1; m_valid = 1;
        end else if (tv) begin
            m_pc = TRAP_PC; m_valid = 1; m_err = 0; m_pending = 0;
        end else if (m_err) begin
            m_valid = 0;
        end else if (rv && (rpc % 4 != 0)) begin
            m_err = 1; m_valid = 0; m_eaddr = rpc; m_pending = 0;
        end else if (rv && !st) begin
            m_pc = rpc; m_valid = 1; m_pending = 0;
        end else if (rv) begin
            m_pend = rpc; m_pending = 1; m_valid = 0;
        end else if (m_pending) begin
            if (!st) begin
                m_pc = m_pend; m_pending = 0; m_valid = 1;
            end
        end else if (!st && fr) begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
    endtask

    // Called 1 time unit after a rising edge. It asserts reset between edges,
    // checks the asynchronous effect, and releases reset away from an edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag, RST_PC, 0, 0, 32'h0);
        edge1();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //           st fr rv rpc           tv  pc            v  e  ea
        vecs[0]  = '{0, 1, 0, 32'h0,        0, 32'h0000_0000, 1, 0, 32'h0};   // BOOT edge
        vecs[1]  = '{0, 1, 0, 32'h0,        0, 32'h0000_0004, 1, 0, 32'h0};
        vecs[2]  = '{0, 1, 0, 32'h0,        0, 32'h0000_0008, 1, 0, 32'h0};
        vecs[3]  = '{0, 1, 0, 32'h0,        0, 32'h0000_000C, 1, 0, 32'h0};
        vecs[4]  = '{0, 1, 0, 32'h0,        0, 32'h0000_0010, 1, 0, 32'h0};
        vecs[5]  = '{0, 1, 1, 32'h200,      0, 32'h0000_0200, 1, 0, 32'h0};
        vecs[6]  = '{0, 1, 0, 32'h0,        0, 32'h0000_0204, 1, 0, 32'h0};
        vecs[7]  = '{1, 1, 1, 32'h300,      0, 32'h0000_0204, 0, 0, 32'h0};
        vecs[8]  = '{1, 1, 1, 32'h400,      0, 32'h0000_0204, 0, 0, 32'h0};
        vecs[9]  = '{1, 1, 0, 32'h0,        0, 32'h0000_0204, 0, 0, 32'h0};
        vecs[10] = '{0, 1, 0, 32'h0,        0, 32'h0000_0400, 1, 0, 32'h0};
        vecs[11] = '{0, 1, 0, 32'h0,        0, 32'h0000_0404, 1, 0, 32'h0};
        vecs[12] = '{0, 1, 1, 32'h202,      0, 32'h0000_0404, 0, 1, 32'h202};
        vecs[13] = '{0, 1, 1, 32'h300,      0, 32'h0000_0404, 0, 1, 32'h202};
        vecs[14] = '{1, 1, 0, 32'h0,        0, 32'h0000_0404, 0, 1, 32'h202};
        vecs[15] = '{0, 1, 0, 32'h0,        1, 32'h0000_0100, 1, 0, 32'h202};
        vecs[16] = '{1, 1, 1, 32'h500,      1, 32'h0000_0100, 1, 0, 32'h202};
        vecs[17] = '{0, 0, 0, 32'h0,        0, 32'h0000_0100, 1, 0, 32'h202};
        vecs[18] = '{0, 1, 0, 32'h0,        0, 32'h0000_0104, 1, 0, 32'h202};
        vecs[19] = '{1, 1, 1, 32'h600,      0, 32'h0000_0104, 0, 0, 32'h202};
        vecs[20] = '{0, 1, 1, 32'h700,      0, 32'h0000_0700, 1, 0, 32'h202};
        vecs[21] = '{0, 1, 0, 32'h0,        0, 32'h0000_0704, 1, 0, 32'h202};

        drive(0, 1, 0, 32'h0, 0);
        #3;
        check_outputs("reset_async", RST_PC, 0, 0, 32'h0);
        edge1();
        check_outputs("reset_held", RST_PC, 0, 0, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].fr, vecs[i].rv, vecs[i].rpc, vecs[i].tv);
            edge1();
            check_outputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].v, vecs[i].e, vecs[i].ea);
        end

        // BOOT ignores trap and redirect
        do_reset("reset_mid_run");
        drive(0, 1, 1, 32'h500, 1);
        edge1();
        check_outputs("boot_ignore", RST_PC, 1, 0, 32'h0);
        drive(0, 0, 0, 32'h0, 0);
        edge1();
        check_outputs("boot_ignore_after", RST_PC, 1, 0, 32'h0);

        // wrap-around
        drive(0, 0, 1, 32'hFFFF_FFFC, 0);
        edge1();
        check_outputs("wrap_load", 32'hFFFF_FFFC, 1, 0, 32'h0);
        drive(0, 1, 0, 32'h0, 0);
        edge1();
        check_outputs("wrap", 32'h0000_0000, 1, 0, 32'h0);

        // asynchronous reset in the middle of PEND
        drive(1, 1, 1, 32'h800, 0);
        edge1();
        check_outputs("pend_enter", 32'h0, 0, 0, 32'h0);
        do_reset("reset_mid_pend");
        drive(0, 1, 0, 32'h0, 0);
        edge1();
        check_outputs("pend_boot", RST_PC, 1, 0, 32'h0);
        edge1();
        check_outputs("pend_dropped", 32'h4, 1, 0, 32'h0);

        // asynchronous reset in the middle of ERR
        drive(0, 1, 1, 32'h13, 0);
        edge1();
        check_outputs("err_enter", 32'h4, 0, 1, 32'h13);
        do_reset("reset_mid_err");

        // randomized run against the behavioural model
        for (int n = 0; n < 500; n++) begin
            bit st, fr, rv, tv;
            logic [31:0] rpc;
            st  = ($urandom % 4) == 0;
            fr  = ($urandom % 4) != 0;
            rv  = ($urandom % 6) == 0;
            tv  = ($urandom % 20) == 0;
            rpc = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 8) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            if (($urandom % 10) == 0) rpc = 32'hFFFF_FFF0;
            if (($urandom % 150) == 0) begin
                do_reset($sformatf("rnd%0d_reset", n));
            end else begin
                drive(st, fr, rv, rpc, tv);
                edge1();
                model_edge(st, fr, rv, rpc, tv);
                check_outputs($sformatf("rnd%0d", n), m_pc, m_valid, m_err, m_eaddr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
